// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
// Holds the FSM state encoding and the default operand width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder built from single-bit full-adder cells.
// Carry out of the top bit is discarded, so the MSB stage is a plain sum.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module ripple_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);
    logic [N-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < N - 1; i++) begin : g_cell
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_carry[i]),
            .o_s (o_sum[i]),
            .o_c (w_carry[i+1])
        );
    end

    // Top stage: its carry would leave the word, so only the sum is formed.
    assign o_sum[N-1] = i_a[N-1] ^ i_b[N-1] ^ w_carry[N-1];
endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement per operation.
// Define SHIFT_ADD_MULT_EARLY_EXIT_EN to finish CALC once the multiplier is exhausted.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] Y,
    output logic               busy,
    output state_t             dbg_state
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P     = PW'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_y;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_y_next;
    logic [WIDTH-1:0] w_mplier_next;
    logic             w_last;

    // Magnitudes fit in WIDTH bits: negating the most negative value gives 2^(WIDTH-1).
    assign w_a_mag = (signed_mode && A[WIDTH-1]) ? (~A + ONE_W) : A;
    assign w_b_mag = (signed_mode && B[WIDTH-1]) ? (~B + ONE_W) : B;

    ripple_adder #(.N(PW)) u_adder (
        .i_a   (r_acc),
        .i_b   (r_mcand),
        .o_sum (w_sum)
    );

    assign w_acc_next    = r_mplier[0] ? w_sum : r_acc;
    assign w_mplier_next = r_mplier >> 1;
    assign w_y_next      = r_sign ? (~w_acc_next + ONE_P) : w_acc_next;

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    assign w_last = (r_cnt == LAST_STEP) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == LAST_STEP);
`endif

    // Handshakes: an input transfer happens on an edge with in_valid && in_ready,
    // an output transfer on an edge with out_valid && out_ready; neither side
    // may depend on the other's readiness, and valid is never withdrawn by the DUT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = CALC;
            CALC:    if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_y      <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                    r_mplier <= w_b_mag;
                    r_sign   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) r_y <= w_y_next;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign Y         = r_y;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and swept checks of shift_add_mult at WIDTH=8; latency expectations
// follow SHIFT_ADD_MULT_EARLY_EXIT_EN when it is defined for the build.
module tb_shift_add_mult;
    import mult_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Y;
    logic        busy;
    state_t      dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    shift_add_mult #(.WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Y           (Y),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 CLK = ~CLK;

    // Reference product computed directly from the operand values.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic sm);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        if (sm) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return 16'(sa * sb);
        end
        return {8'h00, a} * {8'h00, b};
    endfunction

    // Edges from the accepting edge (inclusive) until out_valid is seen high.
    function automatic int exp_lat(input logic [7:0] b, input logic sm);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        logic [7:0] m;
        int hi;
        m  = (sm && b[7]) ? (~b + 8'd1) : b;
        hi = 0;
        for (int i = 0; i < 8; i++) if (m[i]) hi = i;
        return hi + 2;
`else
        return 9;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents one operation, waits (bounded) for out_valid, holds off out_ready
    // for 'hold' cycles, then completes the output handshake.
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                            input int junk, input int hold,
                            output logic [15:0] y_hs, output int lat);
        A = a;
        B = b;
        signed_mode = sm;
        in_valid = 1'b1;
        tick();
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (junk > 0) begin
                A = 8'($urandom);
                B = 8'($urandom);
                signed_mode = 1'($urandom);
                junk--;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        repeat (hold) tick();
        y_hs = Y;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) tick();
        n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (Y !== 16'h0000) begin n_fail++; $display("FAIL reset_y: got %h want 0000", Y); end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_unsigned_max();
        logic [15:0] y;
        int lat;
        drive_op(8'hFF, 8'hFF, 1'b0, 0, 0, y, lat);
        n_cmp++; if (y !== 16'hFE01) begin n_fail++; $display("FAIL unsigned_ff_ff: got %h want fe01", y); end
        n_cmp++; if (lat !== exp_lat(8'hFF, 1'b0)) begin n_fail++; $display("FAIL unsigned_ff_ff_latency: got %0d want %0d", lat, exp_lat(8'hFF, 1'b0)); end
    endtask

    task automatic test_signed_extremes();
        logic [15:0] y;
        int lat;
        drive_op(8'h80, 8'h80, 1'b1, 0, 0, y, lat);
        n_cmp++; if (y !== 16'h4000) begin n_fail++; $display("FAIL signed_80_80: got %h want 4000", y); end
        drive_op(8'h80, 8'h01, 1'b1, 0, 0, y, lat);
        n_cmp++; if (y !== 16'hFF80) begin n_fail++; $display("FAIL signed_80_01: got %h want ff80", y); end
        drive_op(8'hFD, 8'h05, 1'b1, 0, 0, y, lat);
        n_cmp++; if (y !== 16'hFFF1) begin n_fail++; $display("FAIL signed_fd_05: got %h want fff1", y); end
        drive_op(8'h80, 8'h80, 1'b0, 0, 0, y, lat);
        n_cmp++; if (y !== 16'h4000) begin n_fail++; $display("FAIL unsigned_80_80: got %h want 4000", y); end
        drive_op(8'hFD, 8'h05, 1'b0, 0, 0, y, lat);
        n_cmp++; if (y !== 16'h04F1) begin n_fail++; $display("FAIL unsigned_fd_05: got %h want 04f1", y); end
    endtask

    task automatic test_backpressure();
        int lat;
        // 0x12 * 0x34 = 18 * 52 = 936
        A = 8'h12; B = 8'h34; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done: got %b want 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin A = 8'h77; B = 8'h66; signed_mode = 1'b1; in_valid = 1'b1; end
            else in_valid = 1'b0;
            tick();
            n_cmp++; if (Y !== 16'h03A8) begin n_fail++; $display("FAIL bp_y_hold[%0d]: got %h want 03a8", i, Y); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (Y !== 16'h03A8) begin n_fail++; $display("FAIL bp_y_retained: got %h want 03a8", Y); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_pulse_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] y;
        int lat;
        A = 8'hFF; B = 8'hFF; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL midcalc_state: got %0d want %0d", dbg_state, IDLE); end
        n_cmp++; if (Y !== 16'h0000) begin n_fail++; $display("FAIL midcalc_y: got %h want 0000", Y); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midcalc_out_valid: got %b want 0", out_valid); end
        drive_op(8'h0C, 8'h0A, 1'b0, 0, 0, y, lat);
        n_cmp++; if (y !== 16'h0078) begin n_fail++; $display("FAIL midcalc_next_op: got %h want 0078", y); end
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL midcalc_next_latency: got %0d want 5", lat); end
`else
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL midcalc_next_latency: got %0d want 9", lat); end
`endif
    endtask

    task automatic test_early_exit();
        logic [15:0] y;
        int lat;
        int want_b0;
        int want_b1;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        want_b0 = 2; want_b1 = 2;
`else
        want_b0 = 9; want_b1 = 9;
`endif
        drive_op(8'h5A, 8'h00, 1'b0, 0, 0, y, lat);
        n_cmp++; if (y !== 16'h0000) begin n_fail++; $display("FAIL ee_b00_y: got %h want 0000", y); end
        n_cmp++; if (lat !== want_b0) begin n_fail++; $display("FAIL ee_b00_latency: got %0d want %0d", lat, want_b0); end
        drive_op(8'h37, 8'h01, 1'b0, 0, 0, y, lat);
        n_cmp++; if (y !== 16'h0037) begin n_fail++; $display("FAIL ee_b01_y: got %h want 0037", y); end
        n_cmp++; if (lat !== want_b1) begin n_fail++; $display("FAIL ee_b01_latency: got %0d want %0d", lat, want_b1); end
        drive_op(8'h03, 8'h80, 1'b0, 0, 0, y, lat);
        n_cmp++; if (y !== 16'h0180) begin n_fail++; $display("FAIL ee_b80_y: got %h want 0180", y); end
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL ee_b80_latency: got %0d want 9", lat); end
    endtask

    task automatic test_random_sweep();
        logic [15:0] y;
        logic [15:0] exp_y;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        int          lat;
        int          n_done;
        int          lat_bad;
        n_done = 0;
        lat_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            a  = 8'($urandom);
            b  = 8'($urandom);
            sm = 1'($urandom_range(0, 1));
            if (i % 16 == 0) b = 8'h00;
            exp_q.push_back(ref_prod(a, b, sm));
            drive_op(a, b, sm, $urandom_range(0, 2), $urandom_range(0, 3), y, lat);
            n_done++;
            exp_y = exp_q.pop_front();
            n_cmp++;
            if (y !== exp_y) begin
                n_fail++;
                $display("FAIL sweep_y[%0d] a=%h b=%h sm=%b: got %h want %h", i, a, b, sm, y, exp_y);
            end
            if (lat !== exp_lat(b, sm)) lat_bad++;
        end
        n_cmp++; if (lat_bad !== 0) begin n_fail++; $display("FAIL sweep_latency: got %0d wrong want 0", lat_bad); end
        n_cmp++; if (n_done !== 1000) begin n_fail++; $display("FAIL sweep_count: got %0d want 1000", n_done); end
        n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sweep_queue_left: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        RST = 1'b0;
        in_valid = 1'b0;
        A = 8'h00;
        B = 8'h00;
        signed_mode = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed_extremes();
        test_backpressure();
        test_reset_mid_calc();
        test_early_exit();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
